// File: rtl/wb_core_bus_arbiter.sv
// wb_core_bus_arbiter: round-robin two-master Wishbone arbiter with cycle-long grant locking and a slave watchdog.
module wb_core_bus_arbiter #(
    parameter int          AW      = 32,
    parameter int          DW      = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int          CW      = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    output logic [DW-1:0]   m0_dat_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    output logic [DW-1:0]   m1_dat_o,
    output logic            bus_cyc_o,
    output logic            bus_stb_o,
    output logic            bus_we_o,
    output logic [AW-1:0]   bus_adr_o,
    output logic [DW-1:0]   bus_dat_o,
    output logic [DW/8-1:0] bus_sel_o,
    output logic [2:0]      bus_cti_o,
    output logic [1:0]      bus_bte_o,
    input  logic            bus_ack_i,
    input  logic            bus_err_i,
    input  logic            bus_rty_i,
    input  logic [DW-1:0]   bus_dat_i,
    output logic [1:0]      grant_o,
    output logic            timeout_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT0  = 2'd1;
    localparam logic [1:0] GNT1  = 2'd2;
    localparam logic [1:0] ABORT = 2'd3;
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic          req0, req1, gnt, sel1, own_cyc, term, expire;

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i;
    assign gnt     = (state_q == GNT0) || (state_q == GNT1);
    // last already names the aborted master, since it is written on entry to ABORT
    assign sel1    = (state_q == GNT1) || ((state_q == ABORT) && last_q);
    assign own_cyc = sel1 ? m1_cyc_i : m0_cyc_i;
    assign term    = bus_ack_i | bus_err_i | bus_rty_i;
    assign expire  = (TIMEOUT != 0) && gnt && bus_stb_o && !term && (cnt_q == TO_CNT);

    assign bus_cyc_o = gnt && (sel1 ? m1_cyc_i : m0_cyc_i);
    assign bus_stb_o = gnt && (sel1 ? m1_stb_i : m0_stb_i);
    assign bus_we_o  = gnt && (sel1 ? m1_we_i : m0_we_i);
    assign bus_adr_o = gnt ? (sel1 ? m1_adr_i : m0_adr_i) : '0;
    assign bus_dat_o = gnt ? (sel1 ? m1_dat_i : m0_dat_i) : '0;
    assign bus_sel_o = gnt ? (sel1 ? m1_sel_i : m0_sel_i) : '0;
    assign bus_cti_o = gnt ? (sel1 ? m1_cti_i : m0_cti_i) : '0;
    assign bus_bte_o = gnt ? (sel1 ? m1_bte_i : m0_bte_i) : '0;

    assign m0_ack_o  = (state_q == GNT0) && bus_ack_i;
    assign m0_rty_o  = (state_q == GNT0) && bus_rty_i;
    assign m0_err_o  = ((state_q == GNT0) && bus_err_i) || (timeout_q && !last_q);
    assign m1_ack_o  = (state_q == GNT1) && bus_ack_i;
    assign m1_rty_o  = (state_q == GNT1) && bus_rty_i;
    assign m1_err_o  = ((state_q == GNT1) && bus_err_i) || (timeout_q && last_q);
    assign m0_dat_o  = bus_dat_i;
    assign m1_dat_o  = bus_dat_i;
    assign grant_o   = {state_q == GNT1, state_q == GNT0};
    assign timeout_o = timeout_q;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        timeout_d = expire;
        if (state_q == IDLE) begin
            state_d = (req0 && (!req1 || last_q)) ? GNT0 : (req1 ? GNT1 : IDLE);
        end else if (!own_cyc) begin
            state_d = IDLE;
            last_d  = sel1;
        end else if (expire) begin
            state_d = ABORT;
            last_d  = sel1;
        end
        cnt_d = (gnt && (state_d == state_q) && bus_stb_o && !term) ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
endmodule

// File: tb/tb_wb_core_bus_arbiter.sv
// tb_wb_core_bus_arbiter: directed scenarios plus randomized traffic against an ownership-level reference model.
module tb_wb_core_bus_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cyc, stb, we;
    logic [31:0] adr [2];
    logic [31:0] wdat [2];
    logic [3:0]  sel [2];
    logic [2:0]  cti [2];
    logic [1:0]  bte [2];
    logic [1:0]  ack_o, err_o, rty_o;
    logic [31:0] rdat [2];
    logic        bus_cyc, bus_stb, bus_we;
    logic [31:0] bus_adr, bus_dat;
    logic [3:0]  bus_sel;
    logic [2:0]  bus_cti;
    logic [1:0]  bus_bte;
    logic        bus_ack, bus_err, bus_rty;
    logic [31:0] bus_rdat;
    logic [1:0]  grant;
    logic        timeout;

    int n_pass = 0, n_fail = 0, n_tot = 0;

    wb_core_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO), .CW(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
        .m0_dat_i(wdat[0]), .m0_sel_i(sel[0]), .m0_cti_i(cti[0]), .m0_bte_i(bte[0]),
        .m0_ack_o(ack_o[0]), .m0_err_o(err_o[0]), .m0_rty_o(rty_o[0]), .m0_dat_o(rdat[0]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
        .m1_dat_i(wdat[1]), .m1_sel_i(sel[1]), .m1_cti_i(cti[1]), .m1_bte_i(bte[1]),
        .m1_ack_o(ack_o[1]), .m1_err_o(err_o[1]), .m1_rty_o(rty_o[1]), .m1_dat_o(rdat[1]),
        .bus_cyc_o(bus_cyc), .bus_stb_o(bus_stb), .bus_we_o(bus_we), .bus_adr_o(bus_adr),
        .bus_dat_o(bus_dat), .bus_sel_o(bus_sel), .bus_cti_o(bus_cti), .bus_bte_o(bus_bte),
        .bus_ack_i(bus_ack), .bus_err_i(bus_err), .bus_rty_i(bus_rty), .bus_dat_i(bus_rdat),
        .grant_o(grant), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        cyc = '0; stb = '0; we = '0;
        bus_ack = 0; bus_err = 0; bus_rty = 0; bus_rdat = '0;
        for (int m = 0; m < 2; m++) begin
            adr[m] = '0; wdat[m] = '0; sel[m] = '0; cti[m] = '0; bte[m] = '0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        nxt();
        rst = 0;
    endtask

    function automatic logic [127:0] bus_vec();
        return {bus_cyc, bus_stb, bus_we, bus_adr, bus_dat, bus_sel, bus_cti, bus_bte};
    endfunction

    // reference model: who owns the bus, whether it is being aborted, and how long the slave has stalled
    int owner, last_m, stall;
    bit ab, ab1;

    initial begin
        clear_inputs();
        rst = 1;
        nxt(); nxt();
        rst = 0;
        smp();
        chk("rst_grant", grant, 2'b00);
        chk("rst_bus", bus_vec(), '0);
        chk("rst_term", {ack_o, err_o, rty_o, timeout}, '0);

        // single m0 read
        nxt();
        cyc[0] = 1; stb[0] = 1; adr[0] = 32'h0000_0100;
        smp();
        chk("rd_idle_cyc", bus_cyc, 1'b0);
        nxt();
        smp();
        chk("rd_grant", grant, 2'b01);
        chk("rd_cyc", {bus_cyc, bus_stb}, 2'b11);
        chk("rd_adr", bus_adr, 32'h0000_0100);
        nxt();
        nxt();
        bus_ack = 1; bus_rdat = 32'hDEAD_BEEF;
        smp();
        chk("rd_ack0", ack_o, 2'b01);
        chk("rd_dat0", rdat[0], 32'hDEAD_BEEF);
        nxt();
        bus_ack = 0; cyc[0] = 0; stb[0] = 0;
        smp();
        chk("rd_drop_grant", grant, 2'b01);
        nxt();
        smp();
        chk("rd_release", grant, 2'b00);

        // simultaneous requests: m0 first, turnaround, then m1, then m0 again on the next tie
        do_reset();
        cyc = 2'b11; stb = 2'b11; adr[1] = 32'h200;
        smp();
        chk("tie_idle", grant, 2'b00);
        nxt();
        smp();
        chk("tie_first", grant, 2'b01);
        nxt();
        cyc[0] = 0; stb[0] = 0;
        smp();
        chk("tie_hold", grant, 2'b01);
        nxt();
        smp();
        chk("tie_gap", {grant, bus_cyc}, 3'b000);
        nxt();
        smp();
        chk("tie_second", grant, 2'b10);
        chk("tie_adr1", bus_adr, 32'h200);
        nxt();
        cyc = 2'b01; stb = 2'b01;
        smp();
        chk("tie_m0_wait", ack_o, 2'b00);
        nxt();
        cyc = 2'b11; stb = 2'b11;
        smp();
        chk("tie2_idle", grant, 2'b00);
        nxt();
        smp();
        chk("tie2_m0", grant, 2'b01);

        // watchdog abort on a silent slave
        do_reset();
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h300;
        nxt();
        for (int k = 1; k <= 5; k++) begin
            smp();
            chk($sformatf("wd_stall%0d", k), {grant, err_o[1], timeout}, 4'b1000);
            nxt();
        end
        smp();
        chk("wd_abort", {err_o, timeout, bus_cyc, bus_stb, grant}, 7'b1010000);
        nxt();
        bus_ack = 1; cyc[0] = 1; stb[0] = 1;
        smp();
        chk("wd_late_ack", {ack_o, err_o, timeout, bus_cyc}, 6'b0);
        nxt();
        bus_ack = 0; cyc[1] = 0; stb[1] = 0;
        smp();
        chk("wd_hold", grant, 2'b00);
        nxt();
        smp();
        chk("wd_idle", grant, 2'b00);
        nxt();
        smp();
        chk("wd_m0", grant, 2'b01);

        // reset in the middle of an m1 transfer
        do_reset();
        cyc[1] = 1; stb[1] = 1; adr[1] = 32'h440; sel[1] = 4'hF;
        nxt();
        rst = 1;
        smp();
        chk("mid_gnt1", grant, 2'b10);
        nxt();
        rst = 0; bus_ack = 1; cyc[0] = 1; stb[0] = 1;
        smp();
        chk("mid_bus", bus_vec(), '0);
        chk("mid_out", {grant, ack_o, err_o, rty_o, timeout}, '0);
        nxt();
        bus_ack = 0;
        smp();
        chk("mid_tie_m0", grant, 2'b01);

        // randomized traffic
        do_reset();
        owner = -1; last_m = 1; stall = 0; ab = 0; ab1 = 0;
        for (int i = 0; i < 4000; i++) begin
            logic            gr, trm;
            logic [1:0]      e_ack, e_err, e_rty;
            logic [127:0]    e_bus;
            rst = ($urandom_range(0, 299) == 0);
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 7) == 0) cyc[m] = ~cyc[m];
                stb[m] = cyc[m] & ($urandom_range(0, 3) != 0);
                we[m] = 1'($urandom); adr[m] = $urandom; wdat[m] = $urandom;
                sel[m] = 4'($urandom); cti[m] = 3'($urandom); bte[m] = 2'($urandom);
            end
            bus_ack = ($urandom_range(0, 5) == 0);
            bus_err = ($urandom_range(0, 29) == 0);
            bus_rty = ($urandom_range(0, 29) == 0);
            bus_rdat = $urandom;
            smp();
            gr = (owner >= 0) && !ab;
            trm = bus_ack | bus_err | bus_rty;
            e_bus = '0; e_ack = '0; e_err = '0; e_rty = '0;
            if (gr) begin
                e_bus = {cyc[owner], stb[owner], we[owner], adr[owner], wdat[owner],
                         sel[owner], cti[owner], bte[owner]};
                e_ack[owner] = bus_ack; e_err[owner] = bus_err; e_rty[owner] = bus_rty;
            end
            if (ab && ab1) e_err[owner] = 1'b1;
            chk($sformatf("r%0d_bus", i), bus_vec(), e_bus);
            chk($sformatf("r%0d_term", i), {ack_o, err_o, rty_o}, {e_ack, e_err, e_rty});
            chk($sformatf("r%0d_dat", i), {rdat[0], rdat[1]}, {bus_rdat, bus_rdat});
            chk($sformatf("r%0d_grant", i), grant, gr ? 2'(1 << owner) : 2'b00);
            chk($sformatf("r%0d_to", i), timeout, ab && ab1);
            @(posedge clk);
            if (rst) begin
                owner = -1; last_m = 1; stall = 0; ab = 0; ab1 = 0;
            end else if (owner < 0) begin
                if ((cyc[0] & stb[0]) && (cyc[1] & stb[1])) owner = 1 - last_m;
                else if (cyc[0] & stb[0]) owner = 0;
                else if (cyc[1] & stb[1]) owner = 1;
            end else if (!cyc[owner]) begin
                last_m = owner; owner = -1; stall = 0; ab = 0; ab1 = 0;
            end else if (ab) begin
                ab1 = 0;
            end else if (stb[owner] && !trm) begin
                if (stall == TO) begin
                    ab = 1; ab1 = 1; stall = 0;
                end else stall++;
            end else stall = 0;
            #1;
        end
        rst = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/wb_core_bus_arbiter.md
Name: wb_core_bus_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter that shares a single bus master port between a core's instruction port (m0) and data port (m1).
- The data side is normally the output of the atomic (CAS) unit, so a read-modify-write sequence holding cyc high stays atomic.
- Sits between the CPU wrapper and the tile's bus/NoC adapter.
- Provides round-robin arbitration, grant locking over whole cycles (including bursts), and a slave-response watchdog that converts bus hangs into error terminations.

Parameters:
- AW, 32, address width.
- DW, 32, data width; sel width is DW/8.
- TIMEOUT, 255, cycles of stb-without-termination before abort; 0 disables the watchdog.
- CW, 8, watchdog counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- mX_cyc_i, mX_stb_i, mX_we_i  in  1 each  master X request (X = 0 instruction, 1 data).
- mX_adr_i  in  AW  master X address.
- mX_dat_i  in  DW  master X write data.
- mX_sel_i  in  DW/8  master X byte selects.
- mX_cti_i  in  3  master X cycle type.
- mX_bte_i  in  2  master X burst type.
- mX_ack_o, mX_err_o, mX_rty_o  out  1 each  terminations routed to master X.
- mX_dat_o  out  DW  read data to master X.
- bus_cyc_o, bus_stb_o, bus_we_o  out  1 each  shared bus request.
- bus_adr_o  out  AW  shared bus address.
- bus_dat_o  out  DW  shared bus write data.
- bus_sel_o  out  DW/8  shared bus byte selects.
- bus_cti_o  out  3  shared bus cycle type.
- bus_bte_o  out  2  shared bus burst type.
- bus_ack_i, bus_err_i, bus_rty_i  in  1 each  slave terminations.
- bus_dat_i  in  DW  slave read data.
- grant_o  out  2  one-hot current grant; 00 = none.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- State machine states: IDLE, GNT0, GNT1, ABORT. The state register and last-grant bit `last` are the only arbitration storage.
- Reset (rst_i high at a clock edge), applied immediately and also mid-transfer:
  - state = IDLE, last = 1 (so m0 wins the first tie), watchdog count = 0.
  - All bus_* outputs 0; all mX_ack/err/rty = 0; grant_o = 00; timeout_o = 0.
  - An in-flight transfer is dropped without any termination to the master.
- Request: reqX = mX_cyc_i & mX_stb_i.
- IDLE transitions:
  - Only req0 → GNT0. Only req1 → GNT1.
  - Both requesting → grant the master with index != last.
  - Neither → stay in IDLE.
- Grant latency: a request seen in IDLE in cycle N gives the grant state in N+1. bus_cyc_o/bus_stb_o rise combinationally from the granted master's signals in N+1.
- GNTx:
  - bus_* outputs are a combinational mux of master x's inputs.
  - mx_ack/err/rty_o = bus_ack/err/rty_i gated by grant.
  - The other master's ack/err/rty_o are 0.
  - Both mX_dat_o = bus_dat_i, unmuxed.
- Grant release: GNTx holds while mx_cyc_i = 1, which covers cti 010 bursts and locked CAS sequences. When mx_cyc_i = 0, go to IDLE and set last = x.
- Turnaround: there is always at least one IDLE cycle between grants, so bus_cyc_o is low for ≥1 cycle between masters.
- Watchdog (active when TIMEOUT > 0):
  - In GNTx, count increments each cycle with bus_stb_o = 1 and no bus_ack/err/rty_i.
  - It clears on any termination, on leaving GNTx, or while bus_stb_o = 0.
  - When count == TIMEOUT and no termination arrives that cycle, go to ABORT next cycle.
- ABORT, first cycle:
  - mx_err_o = 1 and timeout_o = 1, both for exactly one cycle.
  - bus_cyc_o = bus_stb_o = 0.
  - Late slave acks are ignored and not forwarded.
- ABORT, subsequent cycles:
  - Stay in ABORT with bus_cyc_o = 0 until mx_cyc_i = 0, then go to IDLE with last = x.
- Simultaneous termination and timeout: the termination wins, the count clears, and there is no abort.
- Ownership of mX_ inputs: while not granted, mX_ inputs are ignored. A master waits with cyc/stb held and receives no termination.
- Starvation bound: a waiting master is granted within one release + 1 IDLE cycle of the other master dropping cyc.

Test Plan:
- Reset, then m0 read to adr 0x0000_0100, slave acks 2 cycles later with 0xDEAD_BEEF → bus_cyc_o rises 1 cycle after request; m0_ack_o and m0_dat_o = 0xDEAD_BEEF; m1_ack_o stays 0; grant_o 01 → 00 after cyc drops.
- m0 and m1 both request in the same cycle after reset → m0 granted first (grant_o = 01). After m0 drops cyc: 1 IDLE cycle, then grant_o = 10. A second simultaneous tie → m0 again (last = 1).
- m0 issues a 4-beat burst (cti 010,010,010,111) while m1 requests in beat 2 → m1 is not granted until after beat 4 + m0 cyc drop; bus_adr_o never shows m1 address mid-burst.
- m1 CAS sequence (read 0x200, write 0x200 with cyc held high between) while m0 requests → bus stays with m1 across both accesses; m0 granted only after m1 cyc low.
- TIMEOUT = 4, m1 write with slave silent → after 5 stb cycles: m1_err_o = 1 and timeout_o = 1 for one cycle; bus_cyc_o = 0; a later bus_ack_i is not forwarded; m0 can be granted after m1 drops cyc.
- rst_i asserted during a GNT1 transfer → the next cycle has all outputs 0 and state IDLE; m1 gets no ack; after release, a tie goes to m0.
